// File: rtl/rom_ddr_pkg.sv
// Shared types and constants for the ROM-to-DDR3 bridge.
// Defining ROM_DDR_PREFETCH_EN widens the read cache line to two qwords.
package rom_ddr_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        RD   = 2'd2,
        RDW  = 2'd3
    } state_t;

    localparam int DDR_QW_BITS = 29;

`ifdef ROM_DDR_PREFETCH_EN
    localparam int LINE_QWORDS = 2;
`else
    localparam int LINE_QWORDS = 1;
`endif

    localparam int LINE_BITS = (LINE_QWORDS > 1) ? 1 : 0;

endpackage

// File: rtl/rom_ddr_wrpack.sv
// Write packer: gathers 16-bit download words into one 64-bit qword with byte enables.
module rom_ddr_wrpack #(
    parameter int AW = 25
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [AW-1:0] wraddr,
    input  logic [15:0]   din,
    input  logic          we_req,
    input  logic          absorb_en,
    input  logic          clear,
    output logic          we_ack,
    output logic          we_pend,
    output logic          addr_match,
    output logic          full,
    output logic          nonempty,
    output logic [AW-4:0] wq,
    output logic [63:0]   wbuf,
    output logic [7:0]    wbe
);

    logic [1:0] lane;
    logic       absorb;
    logic       unused_bit0;

    assign unused_bit0 = wraddr[0];
    assign lane        = wraddr[2:1];
    assign we_pend     = we_req ^ we_ack;
    assign addr_match  = (wq == wraddr[AW-1:3]);
    assign nonempty    = |wbe;
    assign full        = &wbe;
    // A word for a different qword waits until the owner of the FSM has flushed the buffer.
    assign absorb      = absorb_en && we_pend && (!nonempty || addr_match);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            we_ack <= 1'b0;
            wq     <= '0;
            wbuf   <= '0;
            wbe    <= '0;
        end else if (clear) begin
            wbuf <= '0;
            wbe  <= '0;
        end else if (absorb) begin
            wq                      <= wraddr[AW-1:3];
            wbuf[{lane, 4'd0} +: 16] <= din;
            wbe[{lane, 1'b0} +: 2]   <= 2'b11;
            we_ack                  <= ~we_ack;
        end
    end

endmodule

// File: rtl/rom_ddr_bridge.sv
// ROM loader / CPU ROM port to DDR3 Avalon bridge: write packer plus a one-line read cache.
// Optional macro ROM_DDR_PREFETCH_EN: 2-qword line filled by a 2-beat burst.
module rom_ddr_bridge
    import rom_ddr_pkg::*;
#(
    parameter logic [DDR_QW_BITS-1:0] DDR_BASE = 29'h0600_0000,
    parameter int                     AW       = 25
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [AW-1:0]          wraddr,
    input  logic [15:0]            din,
    input  logic                   we_req,
    output logic                   we_ack,
    input  logic                   wr_flush,
    input  logic [27:0]            rdaddr,
    input  logic                   rd_req,
    output logic                   rd_ack,
    output logic [63:0]            dout,
    input  logic                   DDRAM_BUSY,
    input  logic [63:0]            DDRAM_DOUT,
    input  logic                   DDRAM_DOUT_READY,
    output logic [DDR_QW_BITS-1:0] DDRAM_ADDR,
    output logic [7:0]             DDRAM_BURSTCNT,
    output logic                   DDRAM_RD,
    output logic                   DDRAM_WE,
    output logic [63:0]            DDRAM_DIN,
    output logic [7:0]             DDRAM_BE,
    output logic [1:0]             dbg_state
);

    // Handshakes: upstream req/ack are toggles; a request is pending while req != ack and
    // the ack toggles once the request is served. A DDR command is held every cycle while
    // DDRAM_BUSY = 1 and is taken on the first cycle it is asserted with DDRAM_BUSY = 0.

    localparam int          TAG_W     = 25 - LINE_BITS;
    localparam logic [24:0] LINE_MASK = ~25'(LINE_QWORDS - 1);

    logic                   we_pend, addr_match, full, nonempty, clear;
    logic [AW-4:0]          wq;
    logic [63:0]            wbuf;
    logic [7:0]             wbe;

    state_t                 state_q, state_d;
    logic                   rd_pend, hit, hit_ack, rd_start, flush_need;
    logic                   last_beat, hit_sel, req_sel;
    logic                   valid_q, beat_q;
    logic [TAG_W-1:0]       tag_q, rd_tag, wq_tag;
    logic [64*LINE_QWORDS-1:0] line_q;
    logic [24:0]            raddr_q, raddr_line;
    logic [2:0]             unused_rd_lsb;

    rom_ddr_wrpack #(.AW(AW)) u_wrpack (
        .clk        (clk),
        .reset_n    (reset_n),
        .wraddr     (wraddr),
        .din        (din),
        .we_req     (we_req),
        .absorb_en  (state_q == IDLE),
        .clear      (clear),
        .we_ack     (we_ack),
        .we_pend    (we_pend),
        .addr_match (addr_match),
        .full       (full),
        .nonempty   (nonempty),
        .wq         (wq),
        .wbuf       (wbuf),
        .wbe        (wbe)
    );

    assign unused_rd_lsb = rdaddr[2:0];
    assign rd_pend    = rd_req ^ rd_ack;
    assign rd_tag     = rdaddr[27:3+LINE_BITS];
    assign wq_tag     = TAG_W'(wq[AW-4:LINE_BITS]);
    assign hit        = valid_q && (tag_q == rd_tag);
    assign hit_sel    = (LINE_QWORDS > 1) ? rdaddr[3] : 1'b0;
    assign req_sel    = (LINE_QWORDS > 1) ? raddr_q[0] : 1'b0;
    assign last_beat  = (LINE_QWORDS == 1) || beat_q;
    assign raddr_line = raddr_q & LINE_MASK;
    // Any pending read drains the buffer first so the cache never hides an acked write.
    assign flush_need = full || (nonempty && (wr_flush || rd_pend || (we_pend && !addr_match)));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        clear    = 1'b0;
        hit_ack  = 1'b0;
        rd_start = 1'b0;
        case (state_q)
            IDLE: begin
                if (flush_need) begin
                    state_d = WR;
                end else if (!we_pend && rd_pend) begin
                    if (hit) begin
                        hit_ack = 1'b1;
                    end else begin
                        rd_start = 1'b1;
                        state_d  = RD;
                    end
                end
            end
            WR: begin
                if (!DDRAM_BUSY) begin
                    clear   = 1'b1;
                    state_d = IDLE;
                end
            end
            RD:      if (!DDRAM_BUSY) state_d = RDW;
            RDW:     if (DDRAM_DOUT_READY && last_beat) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            tag_q   <= '0;
            line_q  <= '0;
            raddr_q <= '0;
            beat_q  <= 1'b0;
            dout    <= '0;
            rd_ack  <= 1'b0;
        end else begin
            if (clear && valid_q && (tag_q == wq_tag)) valid_q <= 1'b0;
            if (hit_ack) begin
                dout   <= line_q[{hit_sel, 6'd0} +: 64];
                rd_ack <= ~rd_ack;
            end
            if (rd_start) begin
                raddr_q <= rdaddr[27:3];
                beat_q  <= 1'b0;
            end
            if (state_q == RDW && DDRAM_DOUT_READY) begin
                line_q[{beat_q, 6'd0} +: 64] <= DDRAM_DOUT;
                if (beat_q == req_sel) begin
                    dout   <= DDRAM_DOUT;
                    rd_ack <= ~rd_ack;
                end
                if (last_beat) begin
                    tag_q   <= raddr_q[24:LINE_BITS];
                    valid_q <= 1'b1;
                end else begin
                    beat_q <= 1'b1;
                end
            end
        end
    end

    assign DDRAM_WE       = (state_q == WR);
    assign DDRAM_RD       = (state_q == RD);
    assign DDRAM_ADDR     = (state_q == WR) ? DDR_BASE + DDR_QW_BITS'(wq)
                                            : DDR_BASE + DDR_QW_BITS'(raddr_line);
    assign DDRAM_BURSTCNT = (state_q == RD) ? 8'(LINE_QWORDS) : 8'd1;
    assign DDRAM_DIN      = wbuf;
    assign DDRAM_BE       = (state_q == WR) ? wbe : 8'h00;
    assign dbg_state      = state_q;

endmodule
